rom_index_gen: RTL
==================

# rom_index_gen

Address and control sequencer directly upstream of the 64x48 CORDIC ROM stage. Loads the 64 table words through a ready/valid stream, then runs a 16-bit phase accumulator. Each running cycle it splits the accumulated phase into the octant, ROM-row and correction indices, and drives the ROM's valid strobe `trans_in`. The ROM/buffer stage consumes its outputs unmodified.

## Interface
- `PHASE_W`, 16, accumulator width; fixed split 3 octant + 6 row + 7 correction bits (must equal 16)
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-low reset
- `start`  in  1  begin RUN (sampled in IDLE only)
- `stop`  in  1  end RUN (sampled in RUN only)
- `phase0`  in  16  initial phase, captured on accepted `start`
- `freq`  in  16  phase increment, captured on accepted `start`
- `load_req`  in  1  begin table load (sampled in IDLE only)
- `load_valid`  in  1  load word valid
- `load_data`  in  48  load word
- `load_ready`  out  1  block accepts a load word this cycle
- `load_done`  out  1  one-cycle pulse after the 64th word is written
- `busy`  out  1  state != IDLE
- `cen`  out  1  ROM enable, high in LOAD and RUN
- `wen`  out  1  ROM write enable, active-low (0 = write)
- `index_wri`  out  6  ROM write address
- `D`  out  48  ROM write data
- `index_qua`  out  3  octant
- `index_rea`  out  6  ROM read row
- `index_cor`  out  7  residual for the correction stage
- `trans_in`  out  1  valid strobe into the ROM stage, high one cycle per issued index set

## Operation
- States: IDLE, LOAD, RUN.
- All outputs are registered.
- **IDLE:**
  - `load_req` -> LOAD: `cnt` <= 0, `load_ready` <= 1.
  - Otherwise `start` -> RUN: `acc` <= `phase0`, `f` <= `freq`.
  - `load_req` and `start` together: LOAD wins and `start` is dropped.
- **LOAD:**
  - Each edge with `load_valid` && `load_ready`: `wen` <= 0, `index_wri` <= `cnt`, `D` <= `load_data`, `cnt` <= `cnt`+1.
  - Edges with no transfer: `wen` <= 1; `index_wri` and `D` hold.
  - On accepting word 63: `load_ready` <= 0, state <= IDLE.
  - One edge later: `wen` <= 1, `load_done` <= 1 for one cycle.
  - `start`, `stop` and `load_req` are ignored in LOAD.
- **RUN:**
  - Each edge: `index_qua` <= `acc[15:13]`, `trans_in` <= 1, `acc` <= (`acc` + `f`) mod 2^16.
  - Octant folding: when `acc[13]`=0, `{index_rea,index_cor}` <= `acc[12:0]`; when `acc[13]`=1, <= `~acc[12:0]`.
  - `stop` -> IDLE: `trans_in` <= 0; index outputs hold their last values.
  - `load_req` and `start` are ignored in RUN.
- `wen` is 1 throughout RUN and IDLE.
- Accumulator wrap from 0xFFFF to 0x0000 is silent; no flag.

## Timing
- Reset values: `index_qua`/`index_rea`/`index_cor` 0, `trans_in` 0, `cen` 0, `wen` 1, `index_wri` 0, `D` 0, `load_ready` 0, `load_done` 0, `busy` 0, `acc` 0, `cnt` 0; state IDLE.
- Reset has priority over every input. Reset mid-LOAD abandons the load: no `load_done`, and rows already written stay written.
- **Start latency:** `start` sampled at edge E0; the first `trans_in`=1 carrying `phase0` is visible after E1. Continuous one index set per cycle thereafter.
- **Stop:** `stop` sampled at edge Ek; the last `trans_in`=1 is the one produced at Ek-1, and `trans_in`=0 after Ek.
- **Load:** a transfer happens in any cycle with `load_valid` && `load_ready`. The write appears on `wen`/`index_wri`/`D` one cycle after the accept, matching the ROM's synchronous write. 64 accepts minimum, 64 cycles back-to-back. `load_done` comes 2 edges after the last accept.
- `busy` is registered with the state.

## Test plan
- **Reset values:** hold `reset`=0 with all inputs toggling -> every output at its reset value; release, idle 5 cycles -> `busy`=0, `wen`=1.
- **Back-to-back load:** `load_req`, then 64 words `load_data`=48'h000000000000+i with `load_valid`=1 -> `wen`=0 for 64 consecutive cycles with `index_wri`=0..63 and matching `D`. `load_done` pulses once, `load_ready` falls after word 63.
- **Throttled load:** `load_valid` toggling every cycle -> `wen` low only on cycles following an accept; address sequence still 0..63, no skips.
- **Run sequence:** `phase0`=16'h0000, `freq`=16'h0400, `start` -> `trans_in` high 2 edges after `start`; `index_qua` 0,0,0,0,0,0,0,0,1,1,…. First four `index_rea` = 0,8,16,24 (`index_cor`=0). At `acc`=16'h2000, `index_rea`=63 and `index_cor`=127 (folded).
- **Wrap and stop:** `phase0`=16'hFFF0, `freq`=16'h0020 -> issued phases 0xFFF0, 0x0010 (`index_qua` 7 then 0). Assert `stop` -> `trans_in` low after that edge, indices hold.
- **Collisions:** `start`+`load_req` in the same IDLE cycle -> LOAD entered, no `trans_in`. `reset` low at word 30 of a load -> IDLE, no `load_done`, `wen`=1.

Source files
------------

// File: rtl/rom_index_gen_if.sv
// Bundle between the ROM index sequencer and its neighbours: control and load stream in,
// ROM write port and index set out.
interface rom_index_gen_if #(
  parameter int PHASE_W = 16
);
  logic               start;
  logic               stop;
  logic [PHASE_W-1:0] phase0;
  logic [PHASE_W-1:0] freq;
  logic               load_req;
  logic               load_valid;
  logic [47:0]        load_data;
  logic               load_ready;
  logic               load_done;
  logic               busy;
  logic               cen;
  logic               wen;
  logic [5:0]         index_wri;
  logic [47:0]        D;
  logic [2:0]         index_qua;
  logic [5:0]         index_rea;
  logic [6:0]         index_cor;
  logic               trans_in;

  modport master (
    output start, stop, phase0, freq, load_req, load_valid, load_data,
    input  load_ready, load_done, busy, cen, wen, index_wri, D,
           index_qua, index_rea, index_cor, trans_in
  );

  modport slave (
    input  start, stop, phase0, freq, load_req, load_valid, load_data,
    output load_ready, load_done, busy, cen, wen, index_wri, D,
           index_qua, index_rea, index_cor, trans_in
  );
endinterface

// File: rtl/rom_index_gen.sv
// Table loader and phase-accumulator index sequencer feeding the 64x48 CORDIC ROM stage.
// IDLE -> LOAD streams 64 words into the ROM; IDLE -> RUN issues one index set per cycle.
module rom_index_gen #(
  parameter int PHASE_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  rom_index_gen_if.slave  bus
);

  localparam int LOW_W = PHASE_W - 3;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t             state_reg, state_next;
  logic [PHASE_W-1:0] acc_reg, acc_next;
  logic [PHASE_W-1:0] f_reg, f_next;
  logic [5:0]         cnt_reg, cnt_next;
  logic               done_pend_reg, done_pend_next;
  logic               load_ready_reg, load_ready_next;
  logic               load_done_reg, load_done_next;
  logic               busy_reg, busy_next;
  logic               cen_reg, cen_next;
  logic               wen_reg, wen_next;
  logic [5:0]         index_wri_reg, index_wri_next;
  logic [47:0]        d_reg, d_next;
  logic [2:0]         index_qua_reg, index_qua_next;
  logic [5:0]         index_rea_reg, index_rea_next;
  logic [6:0]         index_cor_reg, index_cor_next;
  logic               trans_in_reg, trans_in_next;

  logic [LOW_W-1:0]   fold;
  logic               accept;

  // Odd octants read the table backwards: XOR with the octant LSB mirrors the in-octant offset.
  genvar gi;
  generate
    for (gi = 0; gi < LOW_W; gi++) begin : g_fold
      assign fold[gi] = acc_reg[gi] ^ acc_reg[LOW_W];
    end
  endgenerate

  assign accept = bus.load_valid && load_ready_reg;

  always_comb begin
    state_next      = state_reg;
    acc_next        = acc_reg;
    f_next          = f_reg;
    cnt_next        = cnt_reg;
    done_pend_next  = 1'b0;
    load_ready_next = load_ready_reg;
    load_done_next  = done_pend_reg;
    wen_next        = 1'b1;
    index_wri_next  = index_wri_reg;
    d_next          = d_reg;
    index_qua_next  = index_qua_reg;
    index_rea_next  = index_rea_reg;
    index_cor_next  = index_cor_reg;
    trans_in_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.load_req) begin
          state_next      = LOAD;
          cnt_next        = 6'd0;
          load_ready_next = 1'b1;
        end else if (bus.start) begin
          state_next = RUN;
          acc_next   = bus.phase0;
          f_next     = bus.freq;
        end
      end

      LOAD: begin
        if (accept) begin
          wen_next       = 1'b0;
          index_wri_next = cnt_reg;
          d_next         = bus.load_data;
          cnt_next       = cnt_reg + 6'd1;
          // load_done follows one edge later via done_pend, after the last write is presented.
          if (cnt_reg == 6'd63) begin
            load_ready_next = 1'b0;
            state_next      = IDLE;
            done_pend_next  = 1'b1;
          end
        end
      end

      RUN: begin
        if (bus.stop) begin
          state_next = IDLE;
        end else begin
          index_qua_next                   = acc_reg[PHASE_W-1 -: 3];
          {index_rea_next, index_cor_next} = fold;
          trans_in_next                    = 1'b1;
          acc_next                         = acc_reg + f_reg;
        end
      end

      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
    cen_next  = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      acc_reg        <= '0;
      f_reg          <= '0;
      cnt_reg        <= 6'd0;
      done_pend_reg  <= 1'b0;
      load_ready_reg <= 1'b0;
      load_done_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      cen_reg        <= 1'b0;
      wen_reg        <= 1'b1;
      index_wri_reg  <= 6'd0;
      d_reg          <= 48'd0;
      index_qua_reg  <= 3'd0;
      index_rea_reg  <= 6'd0;
      index_cor_reg  <= 7'd0;
      trans_in_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      acc_reg        <= acc_next;
      f_reg          <= f_next;
      cnt_reg        <= cnt_next;
      done_pend_reg  <= done_pend_next;
      load_ready_reg <= load_ready_next;
      load_done_reg  <= load_done_next;
      busy_reg       <= busy_next;
      cen_reg        <= cen_next;
      wen_reg        <= wen_next;
      index_wri_reg  <= index_wri_next;
      d_reg          <= d_next;
      index_qua_reg  <= index_qua_next;
      index_rea_reg  <= index_rea_next;
      index_cor_reg  <= index_cor_next;
      trans_in_reg   <= trans_in_next;
    end
  end

  assign bus.load_ready = load_ready_reg;
  assign bus.load_done  = load_done_reg;
  assign bus.busy       = busy_reg;
  assign bus.cen        = cen_reg;
  assign bus.wen        = wen_reg;
  assign bus.index_wri  = index_wri_reg;
  assign bus.D          = d_reg;
  assign bus.index_qua  = index_qua_reg;
  assign bus.index_rea  = index_rea_reg;
  assign bus.index_cor  = index_cor_reg;
  assign bus.trans_in   = trans_in_reg;

endmodule
